exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of every register, operand and result.
REQ-002 Parameter NUM_REGS, default 8: register-file depth; index width RW = $clog2(NUM_REGS).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  unit can accept an instruction this cycle.
REQ-007 in_opcode  input  opcode_t  operation, shared opcode type from config.sv.
REQ-008 in_rx / in_ry  input  RW each  destination/first-source index and second-source index.
REQ-009 ld_en, ld_addr, ld_data  input  1 / RW / WORD_SIZE  direct register preload.
REQ-010 alu_a, alu_b  output  WORD_SIZE each  operands to the downstream alu.
REQ-011 alu_opcode  output  opcode_t  operation to the alu.
REQ-012 alu_out  input  WORD_SIZE  combinational alu result.
REQ-013 done  output  1  one-cycle pulse: instruction retired.
REQ-014 flags  output  4  {Z,N,C,V}, registered.
REQ-015 dbg_addr / dbg_data  input RW / output WORD_SIZE  asynchronous read of R[dbg_addr].

Function
REQ-016 FSM states IDLE, EXEC, WB; IDLE->EXEC on in_valid&in_ready; EXEC->WB unconditionally; WB->IDLE unconditionally.
REQ-017 in_ready = (state==IDLE) & !ld_en; throughput one instruction per 3 cycles.
REQ-018 Acceptance latches opcode, rx, ry; later in_* changes have no effect on the instruction in flight.
REQ-019 In EXEC: alu_a=R[rx], alu_b=R[ry], alu_opcode=latched opcode; outside EXEC, alu_a=alu_b=0 and alu_opcode=ADD.
REQ-020 EXEC->WB edge: R[rx] and flags are written as per REQ-021..REQ-026; done=1 throughout WB only.
REQ-021 Result res: ADC -> (alu_out + C_old) mod 2^WORD_SIZE; all other opcodes -> alu_out.
REQ-022 CMP updates flags only; R[rx] unchanged. Unrecognised opcode: no register write, flags unchanged, done still pulses.
REQ-023 Z = (res==0); N = res[WORD_SIZE-1].
REQ-024 C: ADD/ADC = carry-out of WORD_SIZE+1-bit a+b(+C_old); SUB = borrow (a<b unsigned); INC = (a==all ones); DEC = (a==0); others 0.
REQ-025 V: ADD/ADC = operands same sign and res sign differs; SUB = operand signs differ and res sign differs from a; others 0.
REQ-026 rx==ry is legal; both operands read the pre-write value.
REQ-027 ld_en in IDLE writes R[ld_addr]=ld_data at the edge; ld_en outside IDLE is ignored; ld_en never changes flags.
REQ-028 ld_en and in_valid together in IDLE: load wins, instruction is not accepted (in_ready=0).

Reset
REQ-029 rst_n low: state=IDLE, all R[i]=0, flags=0, done=0, latched fields=0, immediately and independent of clk.
REQ-030 Reset asserted during EXEC or WB aborts the instruction: no register or flag write, no done pulse.
REQ-031 First accept is possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 Load R1=0x7FFF, R2=0x0001; ADD rx=1 ry=2 -> done 2 cycles after accept, R1=0x8000, flags Z0 N1 C0 V1.
REQ-033 R1=0xFFFF, R2=0x0001; ADD -> R1=0x0000, Z1 C1 V0; then ADC rx=3 (R3=0) ry=3 -> R3=0x0001, C0.
REQ-034 R4=0x0003, R5=0x0005; SUB rx=4 ry=5 -> R4=0xFFFE, N1 C1; CMP rx=5 ry=5 -> R5 unchanged 0x0005, alu_out 1, Z0.
REQ-035 in_valid held high for 6 cycles with two instructions -> exactly two accepts 3 cycles apart, in_ready low in EXEC/WB.
REQ-036 ld_en and in_valid in the same IDLE cycle -> register loaded, instruction accepted next cycle; rst_n pulsed in EXEC -> no done, all R and flags 0.

Source files
------------

// File: rtl/exec_unit.sv
// Three-cycle register-file execution unit: accepts one instruction, drives an
// external combinational ALU in EXEC, and retires result and flags into WB.
package config_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    ADC = 4'd1,
    SUB = 4'd2,
    CMP = 4'd3,
    INC = 4'd4,
    DEC = 4'd5,
    AND = 4'd6,
    OR  = 4'd7,
    XOR = 4'd8
  } opcode_t;

endpackage

module exec_unit
  import config_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 8,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready depends only on state and ld_en.
  input  logic                 in_valid,
  output logic                 in_ready,
  input  opcode_t              in_opcode,
  input  logic [RW-1:0]        in_rx,
  input  logic [RW-1:0]        in_ry,
  input  logic                 ld_en,
  input  logic [RW-1:0]        ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output opcode_t              alu_opcode,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic                 done,
  output logic [3:0]           flags,
  input  logic [RW-1:0]        dbg_addr,
  output logic [WORD_SIZE-1:0] dbg_data,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  opcode_t              op_q;
  logic [RW-1:0]        rx_q, ry_q;
  logic [3:0]           flags_q;

  logic                 accept;
  logic [WORD_SIZE-1:0] op_a, op_b, res;
  logic [WORD_SIZE:0]   sum_ext;
  logic                 c_old, cin, known, wr_reg, wr_flags;
  logic                 z_new, n_new, c_new, v_new;

  assign in_ready  = (state_q == IDLE) && !ld_en;
  assign accept    = in_valid && in_ready;
  assign done      = (state_q == WB);
  assign flags     = flags_q;
  assign dbg_data  = regs_q[dbg_addr];
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= ADD;
      rx_q <= '0;
      ry_q <= '0;
    end else if (accept) begin
      op_q <= in_opcode;
      rx_q <= in_rx;
      ry_q <= in_ry;
    end
  end

  assign op_a  = regs_q[rx_q];
  assign op_b  = regs_q[ry_q];
  assign c_old = flags_q[1];
  assign cin   = (op_q == ADC) && c_old;

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = ADD;
    if (state_q == EXEC) begin
      alu_a      = op_a;
      alu_b      = op_b;
      alu_opcode = op_q;
    end
  end

  // Carry is derived from the operands, not from alu_out, so the flag stays
  // correct even though the ALU itself never sees the incoming carry.
  always_comb begin
    sum_ext = {1'b0, op_a} + {1'b0, op_b} + {{WORD_SIZE{1'b0}}, cin};
    res     = alu_out + {{(WORD_SIZE-1){1'b0}}, cin};
    known   = 1'b1;
    c_new   = 1'b0;
    v_new   = 1'b0;
    case (op_q)
      ADD, ADC: begin
        c_new = (sum_ext > {1'b0, {WORD_SIZE{1'b1}}});
        v_new = (op_a[WORD_SIZE-1] == op_b[WORD_SIZE-1]) &&
                (res[WORD_SIZE-1] != op_a[WORD_SIZE-1]);
      end
      SUB: begin
        c_new = (op_a < op_b);
        v_new = (op_a[WORD_SIZE-1] != op_b[WORD_SIZE-1]) &&
                (res[WORD_SIZE-1] != op_a[WORD_SIZE-1]);
      end
      INC:          c_new = (op_a == {WORD_SIZE{1'b1}});
      DEC:          c_new = (op_a == '0);
      CMP, AND, OR, XOR: c_new = 1'b0;
      default:      known = 1'b0;
    endcase
    z_new    = (res == '0);
    n_new    = res[WORD_SIZE-1];
    wr_flags = (state_q == EXEC) && known;
    wr_reg   = wr_flags && (op_q != CMP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        flags_q <= 4'b0000;
    else if (wr_flags) flags_q <= {z_new, n_new, c_new, v_new};
  end

  // Preload and retirement never collide: one is IDLE-only, the other EXEC-only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_reg) begin
      regs_q[rx_q] <= res;
    end else if (ld_en && (state_q == IDLE)) begin
      regs_q[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Randomized bench for exec_unit: a spec-level arithmetic model of the register
// file and flags, a stand-in ALU, and directed boundary scenarios.
module tb_exec_unit;
  import config_pkg::*;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int RW = 3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, ld_en, done;
  opcode_t       in_opcode, alu_opcode;
  logic [RW-1:0] in_rx, in_ry, ld_addr, dbg_addr;
  logic [W-1:0]  ld_data, alu_a, alu_b, alu_out, dbg_data;
  logic [3:0]    flags;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  logic [W-1:0] m_regs [N];
  logic [3:0]   m_flags;
  logic [W-1:0] exp_q[$];

  exec_unit #(.WORD_SIZE(W), .NUM_REGS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rx(in_rx), .in_ry(in_ry),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .done(done), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  // Downstream ALU stand-in; CMP reports equality as 1.
  always_comb begin
    case (alu_opcode)
      ADD, ADC: alu_out = alu_a + alu_b;
      SUB:      alu_out = alu_a - alu_b;
      CMP:      alu_out = (alu_a == alu_b) ? 16'd1 : 16'd0;
      INC:      alu_out = alu_a + 16'd1;
      DEC:      alu_out = alu_a - 16'd1;
      AND:      alu_out = alu_a & alu_b;
      OR:       alu_out = alu_a | alu_b;
      XOR:      alu_out = alu_a ^ alu_b;
      default:  alu_out = 16'hDEAD;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: whole-number arithmetic on unsigned/signed interpretations.
  task automatic model_exec(input logic [3:0] op, input int rx, input int ry);
    longint m, a, b, sa, sb, s, res;
    bit c, v, wr, known;
    m  = longint'(1) << W;
    a  = longint'(m_regs[rx]);
    b  = longint'(m_regs[ry]);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    c = 0; v = 0; wr = 1; known = 1; res = 0;
    case (op)
      4'd0: begin res = (a + b) % m; c = (a + b) >= m; s = sa + sb; v = (s >= m / 2) || (s < -m / 2); end
      4'd1: begin
        res = (a + b + longint'(m_flags[1])) % m;
        c   = (a + b + longint'(m_flags[1])) >= m;
        s   = sa + sb + longint'(m_flags[1]);
        v   = (s >= m / 2) || (s < -m / 2);
      end
      4'd2: begin res = (a - b + m) % m; c = a < b; s = sa - sb; v = (s >= m / 2) || (s < -m / 2); end
      4'd3: begin res = (a == b) ? 1 : 0; wr = 0; end
      4'd4: begin res = (a + 1) % m; c = (a == m - 1); end
      4'd5: begin res = (a + m - 1) % m; c = (a == 0); end
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      default: known = 0;
    endcase
    if (known) begin
      if (wr) m_regs[rx] = res[W-1:0];
      m_flags = {res == 0, res >= m / 2, c, v};
    end
  endtask

  task automatic check_reg(input int i, input logic [W-1:0] exp);
    dbg_addr = i[RW-1:0];
    #1;
    check($sformatf("R%0d", i), dbg_data, exp);
  endtask

  task automatic check_all_regs();
    for (int i = 0; i < N; i++) check_reg(i, m_regs[i]);
    check("flags", flags, m_flags);
  endtask

  // All driver tasks start and end just after a falling edge.
  task automatic do_load(input int addr, input logic [W-1:0] data);
    ld_en     = 1'b1;
    ld_addr   = addr[RW-1:0];
    ld_data   = data;
    in_valid  = 1'($urandom_range(0, 1));
    in_opcode = ADD;
    #1 check("ld_ready", in_ready, 0);
    @(posedge clk); @(negedge clk);
    ld_en    = 1'b0;
    in_valid = 1'b0;
    m_regs[addr] = data;
    #1 check("ld_state", dbg_state, ST_IDLE);
  endtask

  task automatic issue(input logic [3:0] op, input int rx, input int ry);
    logic [W-1:0] ea, eb, er, ef;
    int d0;
    ea = m_regs[rx];
    eb = m_regs[ry];
    ld_en     = 1'b0;
    in_valid  = 1'b1;
    in_opcode = opcode_t'(op);
    in_rx     = rx[RW-1:0];
    in_ry     = ry[RW-1:0];
    #1;
    check("acc_ready", in_ready, 1);
    check("acc_state", dbg_state, ST_IDLE);
    model_exec(op, rx, ry);
    exp_q.push_back(m_regs[rx]);
    exp_q.push_back({12'h000, m_flags});
    d0 = done_cnt;
    @(posedge clk); @(negedge clk);
    // Scramble inputs: the instruction in flight must not notice.
    in_valid  = 1'($urandom_range(0, 1));
    in_opcode = opcode_t'(4'($urandom_range(0, 15)));
    in_rx     = 3'($urandom_range(0, 7));
    in_ry     = 3'($urandom_range(0, 7));
    ld_en     = 1'b1;
    ld_addr   = 3'($urandom_range(0, 7));
    ld_data   = 16'($urandom);
    #1;
    check("exec_state", dbg_state, ST_EXEC);
    check("exec_ready", in_ready, 0);
    check("exec_done", done, 0);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_op", alu_opcode, op);
    @(posedge clk); @(negedge clk);
    #1;
    check("wb_state", dbg_state, ST_WB);
    check("wb_done", done, 1);
    check("wb_ready", in_ready, 0);
    er = exp_q.pop_front();
    ef = exp_q.pop_front();
    check_reg(rx, er);
    check("wb_flags", flags, ef[3:0]);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    ld_en    = 1'b0;
    #1;
    check("idle_done", done, 0);
    check("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int acc_cyc[$];
    int gap, d0;
    in_valid = 0; in_opcode = ADD; in_rx = 0; in_ry = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0; dbg_addr = 0;
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_flags = 4'b0000;

    repeat (2) @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_done", done, 0);
    check_all_regs();
    rst_n = 1'b1;
    issue(ADD, 0, 0);

    // Signed overflow into the sign bit.
    do_load(1, 16'h7FFF); do_load(2, 16'h0001);
    issue(ADD, 1, 2);
    check_reg(1, 16'h8000);
    check("f_add_ovf", flags, 4'b0101);

    // Wrap to zero with carry, then ADC consumes it.
    do_load(1, 16'hFFFF); do_load(2, 16'h0001);
    issue(ADD, 1, 2);
    check_reg(1, 16'h0000);
    check("f_add_wrap", flags, 4'b1010);
    do_load(3, 16'h0000);
    issue(ADC, 3, 3);
    check_reg(3, 16'h0001);
    check("f_adc", flags, 4'b0000);

    do_load(4, 16'h0003); do_load(5, 16'h0005);
    issue(SUB, 4, 5);
    check_reg(4, 16'hFFFE);
    check("f_sub", flags, 4'b0110);
    issue(CMP, 5, 5);
    check_reg(5, 16'h0005);
    check("f_cmp", flags, 4'b0000);

    // Unrecognised opcode: retires without touching state.
    issue(4'd12, 4, 5);
    check_all_regs();

    // Back-to-back offers with in_valid held high.
    do_load(6, 16'h1234); do_load(7, 16'h00FF);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (acc_cyc.size() == 0) begin in_opcode = ADD; in_rx = 3'd6; in_ry = 3'd7; end
      else begin in_opcode = XOR; in_rx = 3'd7; in_ry = 3'd6; end
      #1;
      if (in_ready) begin
        acc_cyc.push_back(cyc);
        model_exec(in_opcode, int'(in_rx), int'(in_ry));
      end else begin
        check("tp_busy", dbg_state != ST_IDLE, 1);
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    gap = (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1;
    check("tp_accepts", acc_cyc.size(), 2);
    check("tp_gap", gap, 3);
    check_all_regs();

    // Load and offer in the same idle cycle: load wins, accept follows.
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 16'h0101;
    in_valid = 1'b1; in_opcode = INC; in_rx = 3'd2; in_ry = 3'd0;
    #1 check("ldv_ready", in_ready, 0);
    @(posedge clk); @(negedge clk);
    ld_en = 1'b0;
    m_regs[2] = 16'h0101;
    #1 check("ldv_state", dbg_state, ST_IDLE);
    issue(INC, 2, 0);
    check_reg(2, 16'h0102);

    // Reset in EXEC aborts the instruction.
    do_load(1, 16'h00AA);
    d0 = done_cnt;
    in_valid = 1'b1; in_opcode = ADD; in_rx = 3'd1; in_ry = 3'd1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1 check("abort_exec", dbg_state, ST_EXEC);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_flags = 4'b0000;
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_done", done, 0);
    check_all_regs();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("abort_nodone", done_cnt - d0, 0);
    issue(DEC, 0, 0);
    check_reg(0, 16'hFFFF);

    for (int it = 0; it < 60; it++) begin
      int op;
      if ($urandom_range(0, 2) == 0) do_load($urandom_range(0, N - 1), 16'($urandom));
      if ($urandom_range(0, 4) == 0) do_load($urandom_range(0, N - 1), ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h8000);
      op = $urandom_range(0, 10);
      if (op > 8) op = $urandom_range(9, 15);
      issue(4'(op), $urandom_range(0, N - 1), $urandom_range(0, N - 1));
      if (it % 10 == 9) check_all_regs();
    end
    check_all_regs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
